// File: rtl/multicycle_control.sv
// Multicycle control FSM: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and decodes datapath controls from the state and the opcode/func latched in DECODE.
module multicycle_control (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic [1:0]  ImmExt,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Illegal,
  output logic [31:0] Instr_count,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;

  state_t     state;
  logic [5:0] op_q;
  logic [3:0] func_q;

  logic is_rtype, is_load, is_store, is_branch, is_byte, is_zext;
  logic [3:0] alu_op;

  // Only opcode and func feed the controller; register fields go straight to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:4];

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LI, OP_ANDI, OP_ORI,
      OP_BEQ, OP_BNE, OP_B, OP_LW, OP_LB, OP_SW, OP_SB: is_legal = 1'b1;
      default:                                          is_legal = 1'b0;
    endcase
  endfunction

  assign is_rtype  = (op_q == OP_RTYPE);
  assign is_load   = (op_q == OP_LW) || (op_q == OP_LB);
  assign is_store  = (op_q == OP_SW) || (op_q == OP_SB);
  assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_B);
  assign is_byte   = (op_q == OP_LB) || (op_q == OP_SB);
  assign is_zext   = (op_q == OP_ANDI) || (op_q == OP_ORI);

  always_comb begin
    case (op_q)
      OP_RTYPE: alu_op = func_q;
      OP_ANDI:  alu_op = 4'b0010;
      OP_ORI:   alu_op = 4'b0011;
      default:  alu_op = 4'b0000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_FETCH;
      op_q        <= '0;
      func_q      <= '0;
      Instr_count <= '0;
    end else begin
      if (PC_LdEn)
        Instr_count <= Instr_count + 32'd1;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          op_q   <= Instr[31:26];
          func_q <= Instr[3:0];
          state  <= is_legal(Instr[31:26]) ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          if (is_branch)
            state <= S_FETCH;
          else if (is_load || is_store)
            state <= S_MEM;
          else
            state <= S_WB;
        end
        S_MEM:    state <= is_store ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign State = state;

  // Reset masks every control so an aborted instruction commits nothing in its last cycle.
  always_comb begin
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    ImmExt        = 2'b00;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    if (!Reset) begin
      case (state)
        S_DECODE: begin
          IR_LdEn = 1'b1;
          if (!is_legal(Instr[31:26])) begin
            PC_LdEn = 1'b1;
            Illegal = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            ALU_func = 4'b0001;
            RF_B_sel = 1'b1;
            ImmExt   = 2'b10;
            PC_LdEn  = 1'b1;
            PC_sel   = (op_q == OP_B) || ((op_q == OP_BEQ) && Zero) ||
                       ((op_q == OP_BNE) && !Zero);
          end else if (is_load || is_store) begin
            ALU_Bin_sel = 1'b1;
            RF_B_sel    = is_store;
          end else begin
            ALU_Bin_sel = !is_rtype;
            ALU_func    = alu_op;
            ImmExt      = is_zext ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          ByteOp = is_byte;
          if (is_store) begin
            Mem_WrEn = 1'b1;
            PC_LdEn  = 1'b1;
          end
        end
        S_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = is_load;
          PC_LdEn       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked cycle by cycle
// against a per-instruction table of expected control words.
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic [1:0]  ImmExt;
  logic        Mem_WrEn, ByteOp, Illegal;
  logic [31:0] Instr_count;
  logic [2:0]  State;

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .ImmExt(ImmExt), .Mem_WrEn(Mem_WrEn), .ByteOp(ByteOp),
    .Illegal(Illegal), .Instr_count(Instr_count), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_sel, pc_ld, ir_ld, rf_we, rf_ws, rf_bs, alu_bs;
    logic [3:0] fn;
    logic [1:0] ie;
    logic       mem_we, byte_op, ill;
  } cyc_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   model_count = 0;
  cyc_t exp_q[$];

  logic [5:0] legal_ops [12] = '{6'b100000, 6'b110000, 6'b111000, 6'b110010,
                                 6'b110011, 6'b000000, 6'b000001, 6'b111111,
                                 6'b001111, 6'b000011, 6'b011111, 6'b000111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic cyc_t observed();
    return {State, PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
            ALU_Bin_sel, ALU_func, ImmExt, Mem_WrEn, ByteOp, Illegal};
  endfunction

  // Expected control word for every cycle of one instruction.
  function automatic void build_expect(input logic [31:0] ins, input logic z);
    logic [5:0] op;
    logic r, imm, ld, stw, br;
    cyc_t c;
    op  = ins[31:26];
    r   = (op == 6'b100000);
    imm = (op inside {6'b110000, 6'b111000, 6'b110010, 6'b110011});
    ld  = (op inside {6'b001111, 6'b000011});
    stw = (op inside {6'b011111, 6'b000111});
    br  = (op inside {6'b000000, 6'b000001, 6'b111111});
    exp_q.delete();
    c = '0;                       exp_q.push_back(c);
    c = '0; c.st = 3'd1; c.ir_ld = 1'b1;
    if (!(r || imm || ld || stw || br)) begin
      c.pc_ld = 1'b1; c.ill = 1'b1; exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    c = '0; c.st = 3'd2;
    if (r || imm) begin
      c.alu_bs = imm;
      c.fn = r ? ins[3:0] : (op == 6'b110010) ? 4'b0010 : (op == 6'b110011) ? 4'b0011 : 4'b0000;
      c.ie = (op == 6'b110010 || op == 6'b110011) ? 2'b01 : 2'b00;
      exp_q.push_back(c);
      c = '0; c.st = 3'd4; c.rf_we = 1'b1; c.pc_ld = 1'b1; exp_q.push_back(c);
    end else if (br) begin
      c.fn = 4'b0001; c.rf_bs = 1'b1; c.ie = 2'b10; c.pc_ld = 1'b1;
      c.pc_sel = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? z : !z;
      exp_q.push_back(c);
    end else begin
      c.alu_bs = 1'b1; c.rf_bs = stw; exp_q.push_back(c);
      c = '0; c.st = 3'd3; c.byte_op = (op == 6'b000011 || op == 6'b000111);
      if (stw) begin
        c.mem_we = 1'b1; c.pc_ld = 1'b1; exp_q.push_back(c);
      end else begin
        exp_q.push_back(c);
        c = '0; c.st = 3'd4; c.rf_we = 1'b1; c.rf_ws = 1'b1; c.pc_ld = 1'b1;
        exp_q.push_back(c);
      end
    end
  endfunction

  // Entered at posedge+1 of the FETCH cycle; leaves at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int abort_at);
    build_expect(ins, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      Instr = (exp_q[i].st == 3'd1) ? ins : $urandom;
      Zero  = (exp_q[i].st == 3'd2) ? z : 1'($urandom);
      if (i == abort_at) begin
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_cyc_pc_ld", {31'b0, PC_LdEn}, 32'd0);
        check("rst_cyc_rf_we", {31'b0, RF_WrEn}, 32'd0);
        check("rst_cyc_mem_we", {31'b0, Mem_WrEn}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_count = 0;
        check("rst_state", {29'b0, State}, 32'd0);
        check("rst_count", Instr_count, 32'd0);
        return;
      end
      @(negedge Clk);
      if (i == 0) check("count", Instr_count, 32'(model_count));
      check($sformatf("op%b_c%0d", ins[31:26], i), {13'b0, observed()}, {13'b0, exp_q[i]});
      @(posedge Clk); #1;
    end
    model_count++;
  endtask

  initial begin
    logic [5:0] op;
    int idx;
    Reset = 1'b1; Instr = '0; Zero = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("reset_state", {29'b0, State}, 32'd0);
    check("reset_count", Instr_count, 32'd0);
    check("reset_outs", {13'b0, observed()}, 32'd0);

    run_instr(32'h8000_0000, 1'b0, -1);            // add
    run_instr({6'b001111, 26'h0123456}, 1'b0, -1); // lw
    run_instr({6'b011111, 26'h0abcdef}, 1'b1, -1); // sw
    run_instr({6'b000000, 26'h0000010}, 1'b1, -1); // beq taken
    run_instr({6'b000000, 26'h0000010}, 1'b0, -1); // beq not taken
    run_instr({6'b000001, 26'h0000020}, 1'b0, -1); // bne taken
    run_instr({6'b110010, 26'h00000ff}, 1'b0, -1); // andi
    run_instr({6'b101010, 26'h1555555}, 1'b0, -1); // illegal
    run_instr({6'b000011, 26'h0000004}, 1'b0, -1); // lb
    run_instr({6'b000111, 26'h0000008}, 1'b0, -1); // sb
    run_instr({6'b111111, 26'h0000100}, 1'b0, -1); // b
    run_instr({6'b011111, 26'h0000044}, 1'b0, 3);  // sw aborted in MEM
    run_instr(32'h8000_0007, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 13);
      op  = (idx < 12) ? legal_ops[idx] : 6'($urandom);
      run_instr({op, 26'($urandom)}, 1'($urandom), -1);
    end

    @(negedge Clk);
    check("final_count", Instr_count, 32'(model_count));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
